alu_operand_issuer: RTL
=======================

Name: alu_operand_issuer

Overview:
- Front end of an RMT action stage; drives the action/operand inputs of N_LANES per-container ALUs.
- Accepts a PHV plus a VLIW action word through a valid/ready handshake and buffers it in a 2-entry FIFO.
- Decodes each lane's sub-action, selects operands from PHV containers or the action immediate, and issues one registered action_valid/operand set per lane.
- Forwards the PHV alongside so the downstream reassembly sees it aligned with the ALU inputs.

Parameters:
- NUM_CONT, 8: PHV containers, 1..32.
- DATA_WIDTH, 48: container/operand width.
- ACTION_LEN, 25: per-lane sub-action width.
- N_LANES, 8: ALU lanes driven.
- FIFO_DEPTH, 2: input buffer entries, fixed 2 for this revision.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- phv_in  in  NUM_CONT*DATA_WIDTH  flat PHV; container k is bits [k*DATA_WIDTH +: DATA_WIDTH]
- vliw_in  in  N_LANES*ACTION_LEN  lane j sub-action is bits [j*ACTION_LEN +: ACTION_LEN]
- in_valid  in  1  phv_in/vliw_in valid
- in_ready  out  1  issuer can accept
- stall  in  1  downstream hold; no issue while high
- action_out  out  N_LANES*ACTION_LEN  per-lane sub-action to ALU
- action_valid_out  out  1  common valid for all lanes
- operand_1_out  out  N_LANES*DATA_WIDTH  per-lane operand 1
- operand_2_out  out  N_LANES*DATA_WIDTH  per-lane operand 2
- phv_out  out  NUM_CONT*DATA_WIDTH  PHV forwarded with the issue
- idx_err  out  1  sticky: out-of-range container index seen

Behaviour:
- Reset, asynchronous: all outputs 0, FIFO count 0, idx_err 0, in_ready 0 while rst_n is low. in_ready is 1 from the first edge after release.
- Sub-action fields:
  - [24:21] opcode.
  - [20:16] op1 container index.
  - [15:11] op2 container index, used by opcodes 0001/0010/1001/1010.
  - [15:0] immediate, used by opcodes 0011/0100.
- Operand selection per lane:
  - operand_1 = container[op1].
  - operand_2 = container[op2] for add/sub opcodes.
  - operand_2 = zero-extended immediate for 0011/0100.
  - operand_2 = 0 for any other opcode, including 0000 (empty action).
- Index out of range: any used index >= NUM_CONT yields operand 0 for that operand and sets idx_err on the issuing edge; idx_err stays set until reset. An unused op2 field is never checked.
- in_ready = (count < 2), registered from count; it never depends combinationally on in_valid or stall.
- Push when in_valid & in_ready. Pop when count > 0 & ~stall.
- Push and pop in the same cycle: count unchanged. A push at count 2 cannot occur because in_ready is 0.
- Issue timing:
  - A pop at edge t loads the output registers from the FIFO head at edge t.
  - action_valid_out is 1 for exactly one cycle per popped entry.
  - With no pop on an edge, action_valid_out goes 0 and the data outputs hold their last values.
- Latency: entry accepted at edge t into an empty FIFO with stall low pops at edge t+1. Minimum in→out latency is 1 cycle; sustained throughput is 1 PHV/cycle.
- Ordering: strict FIFO; FIFO pointers wrap modulo 2.
- stall high: outputs hold, valid 0, FIFO fills; in_ready drops after the 2nd accept.
- Reset mid-operation: FIFO contents discarded; any in-flight valid cleared immediately.
- action_out passes the sub-action unchanged so the ALU decodes the same opcode.

Optional Feature:
- Macro: ISSUER_STATS_EN.
- Defined: adds output issue_cnt [31:0].
  - Increments on every action_valid_out edge and wraps at 2^32.
  - Adds output stall_cnt [31:0], which increments each cycle that stall & count>0.
  - Both counters reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package rmt_action_pkg:
  - opcode localparams OP_ADD=4'b0001, OP_SUB=4'b0010, OP_ADDI=4'b0011, OP_SUBI=4'b0100, OP_ADD_ALT=4'b1001, OP_SUB_ALT=4'b1010.
  - field bit positions.
  - DATA_WIDTH/ACTION_LEN defaults.
- One sub-module: issuer_lane_decode, combinational per-lane operand select plus range check, instantiated N_LANES times via generate.
- The FIFO and output registers stay in the top module.

Test Plan:
- Reset release, idle: all outputs 0, in_ready=1 after the first edge, idx_err=0.
- Lane 0 sub-action {0001,op1=2,op2=5}, c2=10, c5=3: one cycle later action_valid_out=1, operand_1=10, operand_2=3, action_out equal to input.
- Lane 1 {0011,op1=0,imm=16'hFFFF}, c0=7: operand_1=7, operand_2=48'h00000000FFFF (zero-extended).
- stall=1, 3 back-to-back pushes: first 2 accepted, in_ready=0; release stall: 2 issues in order, in_ready returns to 1.
- Lane 2 {0010,op1=9,op2=1} with NUM_CONT=8: operand_1=0, idx_err=1 and stays 1. Lane {0011,op1=0,imm=16'hF800}: op2 bits not checked, no error.
- Assert rst_n mid-stream with 2 entries queued: valid drops immediately, no stale issue after release. With ISSUER_STATS_EN, issue_cnt reads 0.

Source files
------------

// File: rtl/rmt_action_pkg.sv
// rmt_action_pkg: opcodes, sub-action field positions and width defaults for the action stage
package rmt_action_pkg;
    localparam int DATA_WIDTH_DEF = 48;
    localparam int ACTION_LEN_DEF = 25;
    localparam logic [3:0] OP_ADD     = 4'b0001;
    localparam logic [3:0] OP_SUB     = 4'b0010;
    localparam logic [3:0] OP_ADDI    = 4'b0011;
    localparam logic [3:0] OP_SUBI    = 4'b0100;
    localparam logic [3:0] OP_ADD_ALT = 4'b1001;
    localparam logic [3:0] OP_SUB_ALT = 4'b1010;
    localparam int OPC_LSB = 21;
    localparam int OP1_LSB = 16;
    localparam int OP2_LSB = 11;
    localparam int IMM_LSB = 0;

    function automatic logic uses_op2(input logic [3:0] opc);
        return opc == OP_ADD || opc == OP_SUB || opc == OP_ADD_ALT || opc == OP_SUB_ALT;
    endfunction

    function automatic logic uses_imm(input logic [3:0] opc);
        return opc == OP_ADDI || opc == OP_SUBI;
    endfunction
endpackage

// File: rtl/issuer_lane_decode.sv
// issuer_lane_decode: per-lane operand select from PHV containers or immediate, with index range check
module issuer_lane_decode
    import rmt_action_pkg::*;
#(
    parameter int NUM_CONT   = 8,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACTION_LEN = ACTION_LEN_DEF
) (
    input  logic [NUM_CONT*DATA_WIDTH-1:0] phv,
    input  logic [ACTION_LEN-1:0]          action,
    output logic [DATA_WIDTH-1:0]          operand_1,
    output logic [DATA_WIDTH-1:0]          operand_2,
    output logic                           err
);
    logic [3:0]            opc;
    logic [4:0]            i1, i2;
    logic [15:0]           imm;
    logic [DATA_WIDTH-1:0] c2;
    logic                  hit1, hit2;

    assign opc = action[OPC_LSB +: 4];
    assign i1  = action[OP1_LSB +: 5];
    assign i2  = action[OP2_LSB +: 5];
    assign imm = action[IMM_LSB +: 16];

    // a miss on the container scan leaves the operand at zero and flags the index
    always_comb begin
        operand_1 = '0;
        c2        = '0;
        hit1      = 1'b0;
        hit2      = 1'b0;
        for (int k = 0; k < NUM_CONT; k++) begin
            if (i1 == 5'(k)) begin
                operand_1 = phv[k*DATA_WIDTH +: DATA_WIDTH];
                hit1      = 1'b1;
            end
            if (i2 == 5'(k)) begin
                c2   = phv[k*DATA_WIDTH +: DATA_WIDTH];
                hit2 = 1'b1;
            end
        end
        operand_2 = uses_op2(opc) ? c2 : uses_imm(opc) ? DATA_WIDTH'(imm) : '0;
        err       = ~hit1 | (uses_op2(opc) & ~hit2);
    end
endmodule

// File: rtl/alu_operand_issuer.sv
// alu_operand_issuer: 2-entry PHV/VLIW buffer issuing registered per-lane ALU operands.
// Define ISSUER_STATS_EN to add issue_cnt/stall_cnt counters.
module alu_operand_issuer
    import rmt_action_pkg::*;
#(
    parameter int NUM_CONT   = 8,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACTION_LEN = ACTION_LEN_DEF,
    parameter int N_LANES    = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CONT*DATA_WIDTH-1:0] phv_in,
    input  logic [N_LANES*ACTION_LEN-1:0]  vliw_in,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           stall,
    output logic [N_LANES*ACTION_LEN-1:0]  action_out,
    output logic                           action_valid_out,
    output logic [N_LANES*DATA_WIDTH-1:0]  operand_1_out,
    output logic [N_LANES*DATA_WIDTH-1:0]  operand_2_out,
    output logic [NUM_CONT*DATA_WIDTH-1:0] phv_out,
    output logic                           idx_err
`ifdef ISSUER_STATS_EN
    ,
    output logic [31:0]                    issue_cnt,
    output logic [31:0]                    stall_cnt
`endif
);
    logic [NUM_CONT*DATA_WIDTH-1:0] phv_q  [FIFO_DEPTH];
    logic [N_LANES*ACTION_LEN-1:0]  vliw_q [FIFO_DEPTH];
    logic [1:0]                     count, count_nxt;
    logic                           wr_ptr, rd_ptr, push, pop;
    logic [N_LANES*DATA_WIDTH-1:0]  op1_w, op2_w;
    logic [N_LANES-1:0]             lane_err;

    assign push      = in_valid & in_ready;
    assign pop       = (count != 2'd0) & ~stall;
    assign count_nxt = count + 2'(push) - 2'(pop);

    for (genvar j = 0; j < N_LANES; j++) begin : g_lane
        issuer_lane_decode #(
            .NUM_CONT  (NUM_CONT),
            .DATA_WIDTH(DATA_WIDTH),
            .ACTION_LEN(ACTION_LEN)
        ) u_dec (
            .phv      (phv_q[rd_ptr]),
            .action   (vliw_q[rd_ptr][j*ACTION_LEN +: ACTION_LEN]),
            .operand_1(op1_w[j*DATA_WIDTH +: DATA_WIDTH]),
            .operand_2(op2_w[j*DATA_WIDTH +: DATA_WIDTH]),
            .err      (lane_err[j])
        );
    end

    always_ff @(posedge clk) begin
        if (push) begin
            phv_q[wr_ptr]  <= phv_in;
            vliw_q[wr_ptr] <= vliw_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count            <= '0;
            wr_ptr           <= 1'b0;
            rd_ptr           <= 1'b0;
            in_ready         <= 1'b0;
            action_valid_out <= 1'b0;
            action_out       <= '0;
            operand_1_out    <= '0;
            operand_2_out    <= '0;
            phv_out          <= '0;
            idx_err          <= 1'b0;
        end else begin
            count            <= count_nxt;
            wr_ptr           <= wr_ptr ^ push;
            rd_ptr           <= rd_ptr ^ pop;
            in_ready         <= int'(count_nxt) < FIFO_DEPTH;
            action_valid_out <= pop;
            if (pop) begin
                action_out    <= vliw_q[rd_ptr];
                operand_1_out <= op1_w;
                operand_2_out <= op2_w;
                phv_out       <= phv_q[rd_ptr];
                idx_err       <= idx_err | (|lane_err);
            end
        end
    end

`ifdef ISSUER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            issue_cnt <= issue_cnt + 32'(pop);
            stall_cnt <= stall_cnt + 32'(stall & (count != 2'd0));
        end
    end
`endif
endmodule
